// File: rtl/key_pulse_gen.sv
// key_pulse_gen
// Pushbutton conditioning for the hex counter enable. The raw active-low key
// is synchronised, debounced into a clean level, and turned into one-cycle
// enable pulses: one per accepted press, plus optional auto-repeat pulses
// while the key stays held.
//
// Ports
//   clock        system clock, rising edge
//   clear        asynchronous active-high reset
//   key_n        raw pushbutton, 0 = pressed, asynchronous to clock
//   repeat_en    1 = auto-repeat while the key is held
//   key_level    debounced key state, 1 = pressed (registered)
//   enable_pulse one-cycle pulse per press or repeat (registered)
module key_pulse_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic clock,
  input  logic clear,
  input  logic key_n,
  input  logic repeat_en,
  output logic key_level,
  output logic enable_pulse
);

  // Shared width for the debounce counter and the repeat timer; both count
  // up to at most (largest parameter - 1) and are cleared before wrapping.
  localparam int unsigned MAX_DR = (DEBOUNCE_CYCLES > REPEAT_DELAY) ?
                                   DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int unsigned MAX_ALL = (MAX_DR > REPEAT_PERIOD) ?
                                    MAX_DR : REPEAT_PERIOD;
  localparam int unsigned CW = (MAX_ALL > 2) ? $clog2(MAX_ALL) : 1;

  localparam logic [CW-1:0] DB_LAST     = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);
  localparam logic [CW-1:0] ONE         = CW'(1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    HELD_DELAY  = 2'd1,
    HELD_REPEAT = 2'd2
  } state_t;

  logic          sync_meta;
  logic          key_sync;
  logic [CW-1:0] db_count;
  state_t        state;
  logic [CW-1:0] timer;

  // Two-flop synchroniser on the inverted key so that 1 means pressed.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      sync_meta <= 1'b0;
      key_sync  <= 1'b0;
    end else begin
      sync_meta <= ~key_n;
      key_sync  <= sync_meta;
    end
  end

  // Debounce: a level change is accepted only after DEBOUNCE_CYCLES
  // consecutive disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      db_count  <= '0;
      key_level <= 1'b0;
    end else if (key_sync == key_level) begin
      db_count <= '0;
    end else if (db_count == DB_LAST) begin
      key_level <= ~key_level;
      db_count  <= '0;
    end else begin
      db_count <= db_count + ONE;
    end
  end

  // Press / auto-repeat FSM. Release is tested first in every held state so
  // it wins over a simultaneous timer expiry; releasing never pulses.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state        <= IDLE;
      timer        <= '0;
      enable_pulse <= 1'b0;
    end else begin
      enable_pulse <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (key_level) begin
            enable_pulse <= 1'b1;
            state        <= HELD_DELAY;
          end
        end

        HELD_DELAY: begin
          if (!key_level) begin
            state <= IDLE;
            timer <= '0;
          end else if (!repeat_en) begin
            timer <= '0;
          end else if (timer == DELAY_LAST) begin
            enable_pulse <= 1'b1;
            state        <= HELD_REPEAT;
            timer        <= '0;
          end else begin
            timer <= timer + ONE;
          end
        end

        HELD_REPEAT: begin
          if (!key_level) begin
            state <= IDLE;
            timer <= '0;
          end else if (!repeat_en) begin
            // Re-arm the full initial delay when repeat is re-enabled.
            state <= HELD_DELAY;
            timer <= '0;
          end else if (timer == PERIOD_LAST) begin
            enable_pulse <= 1'b1;
            timer        <= '0;
          end else begin
            timer <= timer + ONE;
          end
        end

        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_pulse_gen.sv
// Bench for key_pulse_gen: directed scenarios with hand-derived pulse edges,
// then randomized key/repeat/clear activity against a schedule-based model.
module tb_key_pulse_gen;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic clock = 1'b0;
  logic clear;
  logic key_n;
  logic repeat_en;
  logic key_level;
  logic enable_pulse;

  key_pulse_gen #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clock       (clock),
    .clear       (clear),
    .key_n       (key_n),
    .repeat_en   (repeat_en),
    .key_level   (key_level),
    .enable_pulse(enable_pulse)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mark     = 0;
  int pulse_q[$];
  int exp_q[$];

  // Reference model state: raw key samples in flight, recent synchronised
  // samples, and the edge number at which the next repeat pulse is due.
  bit raw_q[$];
  bit ks_hist[$];
  bit m_kl;
  bit m_held;
  bit m_pulse;
  int m_due;
  int m_edge = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    raw_q.delete();
    raw_q.push_back(1'b0);
    raw_q.push_back(1'b0);
    ks_hist.delete();
    m_kl    = 1'b0;
    m_held  = 1'b0;
    m_pulse = 1'b0;
    m_due   = 0;
  endtask

  // Advance the model by one clock edge using the inputs present before it.
  task automatic model_edge();
    bit ks;
    bit kl_pre;
    bit all_diff;
    m_edge++;
    if (clear) begin
      model_reset();
      return;
    end
    ks = raw_q.pop_front();
    raw_q.push_back(!key_n);
    kl_pre  = m_kl;
    m_pulse = 1'b0;
    if (!m_held) begin
      if (kl_pre) begin
        m_pulse = 1'b1;
        m_held  = 1'b1;
        m_due   = m_edge + RD;
      end
    end else if (!kl_pre) begin
      m_held = 1'b0;
    end else if (!repeat_en) begin
      m_due = m_edge + RD;
    end else if (m_edge == m_due) begin
      m_pulse = 1'b1;
      m_due   = m_edge + RP;
    end
    // Level flips once the last DB synchronised samples all disagree with it.
    ks_hist.push_back(ks);
    if (ks_hist.size() > DB) void'(ks_hist.pop_front());
    if (ks_hist.size() == DB) begin
      all_diff = 1'b1;
      foreach (ks_hist[i]) if (ks_hist[i] == kl_pre) all_diff = 1'b0;
      if (all_diff) begin
        m_kl = !kl_pre;
        ks_hist.delete();
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    check("key_level", key_level, m_kl);
    check("enable_pulse", enable_pulse, m_pulse);
    if (enable_pulse === 1'b1) pulse_q.push_back(cyc - mark);
    cyc++;
  endtask

  task automatic check_pulses(input string tag);
    check({tag, "_count"}, pulse_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < pulse_q.size()) check({tag, "_edge"}, pulse_q[i], exp_q[i]);
    end
    pulse_q.delete();
  endtask

  task automatic start_seg();
    mark = cyc;
    pulse_q.delete();
  endtask

  initial begin
    bit bounce[7];
    int run;
    bounce = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    clear = 1'b0;
    key_n = 1'b0;
    repeat_en = 1'b0;
    #1 clear = 1'b1;
    model_reset();
    #1;
    check("reset_key_level", key_level, 0);
    check("reset_enable_pulse", enable_pulse, 0);

    // 1: key pressed under clear, then first pulse 6 edges after release of clear
    repeat (5) tick();
    clear = 1'b0;
    start_seg();
    repeat (10) tick();
    exp_q = {6};
    check_pulses("s1_post_clear");
    key_n = 1'b1;
    repeat (10) tick();

    // 2: clean press without repeat
    start_seg();
    key_n = 1'b0;
    repeat (5) tick();
    check("s2_level_edge4", key_level, 0);
    tick();
    check("s2_level_edge5", key_level, 1);
    repeat (14) tick();
    exp_q = {6};
    check_pulses("s2_single");
    key_n = 1'b1;
    repeat (10) tick();

    // 3: bounce shorter than the debounce window
    start_seg();
    foreach (bounce[i]) begin
      key_n = bounce[i];
      tick();
    end
    key_n = 1'b1;
    repeat (10) tick();
    check("s3_level", key_level, 0);
    exp_q = {};
    check_pulses("s3_bounce");

    // 4: auto-repeat through edge 40
    repeat_en = 1'b1;
    start_seg();
    key_n = 1'b0;
    repeat (41) tick();
    check("s4_pulse_edge40", enable_pulse, 1);
    exp_q = {6, 16, 19, 22, 25, 28, 31, 34, 37, 40};
    check_pulses("s4_repeat");

    // 5: asynchronous clear while a repeat pulse is high, key still held
    clear = 1'b1;
    #1;
    check("s5_async_level", key_level, 0);
    check("s5_async_pulse", enable_pulse, 0);
    model_reset();
    repeat (2) tick();
    clear = 1'b0;
    start_seg();
    repeat (16) tick();
    // 6: release so key_level is already low when the period timer expires at edge 22
    key_n = 1'b1;
    repeat (15) tick();
    exp_q = {6, 16, 19};
    check_pulses("s5_s6_release_collision");
    check("s6_level_released", key_level, 0);

    start_seg();
    key_n = 1'b0;
    repeat (10) tick();
    exp_q = {6};
    check_pulses("s6_repress");
    key_n = 1'b1;
    repeat (12) tick();

    // Randomized activity checked every edge against the model
    run = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run == 0) begin
        key_n = 1'($urandom_range(0, 1));
        run = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                          : int'($urandom_range(5, 40));
      end
      run--;
      if ($urandom_range(0, 59) == 0) repeat_en = !repeat_en;
      clear = ($urandom_range(0, 399) == 0);
      tick();
    end
    clear = 1'b0;
    pulse_q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
